// File: rtl/rom_error_fp_gen.sv
// rom_error_fp_gen
// Once per sample tick this block reads one reference-profile word from an
// external synchronous ROM and forms the signed error vref - rom_data. It then
// converts that error to an IEEE-754 double and pulses e0ready for one cycle.
//
// Ports
//   clk       system clock; all logic runs on the rising edge
//   rst       synchronous reset, active-high
//   clk_Fs    sample-rate level; its rising edge is detected in the clk domain
//   en        enables acceptance of new ticks
//   vref_ld   loads vref_in into the vref register
//   vref_in   unsigned reference value (W bits)
//   rom_addr  ROM address (AW bits)
//   rom_data  ROM read data, valid ROM_LAT cycles after rom_addr is stable
//   err_int   registered signed error (W+1 bits)
//   e0        IEEE-754 double of err_int
//   e0ready   one-cycle result strobe
//   busy      high while a conversion is in flight
//   end_flag  sticky; last word consumed with WRAP=0
//   overrun   sticky; an enabled tick arrived while busy
//
// state | meaning
// IDLE  | waiting for an accepted tick
// WAIT  | ROM read in flight, rom_addr held for ROM_LAT cycles
// CALC  | err_int <= vref - rom_data
// CONV  | e0 <= double(err_int)
// DONE  | raise e0ready on exit and advance the address
module rom_error_fp_gen #(
   parameter int W          = 12,
   parameter int AW         = 11,
   parameter int DEPTH      = 2048,
   parameter int START_ADDR = 0,
   parameter int ROM_LAT    = 1,
   parameter int WRAP       = 1,
   parameter int VREF_NUM   = 15,
   parameter int VREF_DEN   = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clk_Fs,
   input  logic          en,
   input  logic          vref_ld,
   input  logic [W-1:0]  vref_in,
   output logic [AW-1:0] rom_addr,
   input  logic [W-1:0]  rom_data,
   output logic [W:0]    err_int,
   output logic [63:0]   e0,
   output logic          e0ready,
   output logic          busy,
   output logic          end_flag,
   output logic          overrun
);

   localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam logic [63:0] VMAX     = (64'd1 << W) - 64'd1;
   localparam logic [63:0] VREF_DEF = (VMAX * 64'(VREF_NUM)) / 64'(VREF_DEN);
   localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WAIT = 3'd1,
      CALC = 3'd2,
      CONV = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t         state, state_nxt;
   logic           clk_fs_q;
   logic           tick;
   logic           accept;
   logic [W-1:0]   vref;
   logic [CW-1:0]  wait_cnt;

   logic [W:0]     mag;
   logic [5:0]     msb;
   logic [10:0]    exp_f;
   logic [51:0]    mant;
   logic [63:0]    dbl;
   int             sh;

   assign tick   = clk_Fs & ~clk_fs_q;
   assign busy   = (state != IDLE);
   assign accept = tick & en & ~end_flag & (state == IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = WAIT;
         WAIT: if (wait_cnt == '0) state_nxt = CALC;
         CALC: state_nxt = CONV;
         CONV: state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Magnitude never exceeds 2^W-1, so a shift of at least 52-32 keeps every
   // bit below the leading one inside the mantissa: the conversion is exact.
   always_comb begin
      mag = err_int[W] ? (~err_int + 1'b1) : err_int;
      msb = '0;
      for (int i = 0; i <= W; i++) begin
         if (mag[i]) msb = 6'(i);
      end
      sh    = 52 - int'(msb);
      mant  = 52'(mag) << sh;
      exp_f = 11'd1023 + 11'(msb);
      dbl   = (err_int == '0) ? 64'h0 : {err_int[W], exp_f, mant};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         clk_fs_q <= 1'b0;
         vref     <= W'(VREF_DEF);
         wait_cnt <= '0;
         rom_addr <= AW'(START_ADDR);
         err_int  <= '0;
         e0       <= '0;
         e0ready  <= 1'b0;
         end_flag <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nxt;
         clk_fs_q <= clk_Fs;
         e0ready  <= (state == DONE);
         if (vref_ld) vref <= vref_in;
         if (accept)
            wait_cnt <= CW'(ROM_LAT - 1);
         else if ((state == WAIT) && (wait_cnt != '0))
            wait_cnt <= wait_cnt - 1'b1;
         if (state == CALC) err_int <= {1'b0, vref} - {1'b0, rom_data};
         if (state == CONV) e0 <= dbl;
         if (state == DONE) begin
            if (rom_addr == LAST) begin
               if (WRAP != 0) rom_addr <= '0;
               else           end_flag <= 1'b1;
            end else begin
               rom_addr <= rom_addr + 1'b1;
            end
         end
         if (tick & en & busy) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rom_error_fp_gen.sv
module tb_rom_error_fp_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic rst, en, vref_ld;
   logic [11:0] vref_in;

   // main instance: default parameters, ROM latency 1
   logic        clk_fs_m;
   logic [10:0] addr_m;
   logic [11:0] rd_m;
   logic [12:0] err_m;
   logic [63:0] e0_m;
   logic        e0ready_m, busy_m, end_m, ovr_m;
   logic [11:0] rom_m [0:15];

   rom_error_fp_gen dut_m (
      .clk(clk), .rst(rst), .clk_Fs(clk_fs_m), .en(en), .vref_ld(vref_ld),
      .vref_in(vref_in), .rom_addr(addr_m), .rom_data(rd_m), .err_int(err_m),
      .e0(e0_m), .e0ready(e0ready_m), .busy(busy_m), .end_flag(end_m),
      .overrun(ovr_m));

   always @(posedge clk) rd_m <= rom_m[addr_m[3:0]];

   // small instances: W=8, DEPTH=4, ROM latency 2, wrapping and stopping
   logic       clk_fs_s;
   logic       one = 1'b1;
   logic       zero = 1'b0;
   logic [7:0] vin_s = 8'd0;
   logic [1:0] addr_w, addr_s;
   logic [7:0] d1_w, d2_w, d1_s, d2_s;
   logic [8:0] err_w, err_s;
   logic [63:0] e0_w, e0_s;
   logic e0ready_w, busy_w, end_w, ovr_w;
   logic e0ready_s, busy_s, end_s, ovr_s;

   rom_error_fp_gen #(.W(8), .AW(2), .DEPTH(4), .ROM_LAT(2), .WRAP(1)) dut_w (
      .clk(clk), .rst(rst), .clk_Fs(clk_fs_s), .en(one), .vref_ld(zero),
      .vref_in(vin_s), .rom_addr(addr_w), .rom_data(d2_w), .err_int(err_w),
      .e0(e0_w), .e0ready(e0ready_w), .busy(busy_w), .end_flag(end_w),
      .overrun(ovr_w));

   rom_error_fp_gen #(.W(8), .AW(2), .DEPTH(4), .ROM_LAT(2), .WRAP(0)) dut_s (
      .clk(clk), .rst(rst), .clk_Fs(clk_fs_s), .en(one), .vref_ld(zero),
      .vref_in(vin_s), .rom_addr(addr_s), .rom_data(d2_s), .err_int(err_s),
      .e0(e0_s), .e0ready(e0ready_s), .busy(busy_s), .end_flag(end_s),
      .overrun(ovr_s));

   always @(posedge clk) begin
      d1_w <= 8'(addr_w) * 8'd10;
      d2_w <= d1_w;
      d1_s <= 8'(addr_s) * 8'd10;
      d2_s <= d1_s;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // lat = cycles from the tick-sampling edge to the first e0ready seen;
   // optional second rising edge sampled second_at cycles after the first
   task automatic run_tick(input int second_at, output int lat, output int np);
      lat = -1;
      np  = 0;
      @(negedge clk); clk_fs_m = 1'b1;
      @(posedge clk); #1; clk_fs_m = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (e0ready_m) begin
            np++;
            if (lat < 0) lat = k;
         end
         clk_fs_m = (second_at > 0) && (k == second_at - 1);
      end
   endtask

   task automatic run_tick_s(output int lat_w, output int np_w, output int lat_s, output int np_s);
      lat_w = -1; np_w = 0; lat_s = -1; np_s = 0;
      @(negedge clk); clk_fs_s = 1'b1;
      @(posedge clk); #1; clk_fs_s = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (e0ready_w) begin np_w++; if (lat_w < 0) lat_w = k; end
         if (e0ready_s) begin np_s++; if (lat_s < 0) lat_s = k; end
      end
   endtask

   initial begin
      int lat, np, lw, nw, ls, ns, t3;
      for (int i = 0; i < 16; i++) rom_m[i] = 12'd0;
      rom_m[1] = 12'd4095;
      rom_m[2] = 12'd3071;
      rom_m[3] = 12'd100;
      rom_m[4] = 12'd2047;
      rst = 1'b1; en = 1'b1; vref_ld = 1'b0; vref_in = 12'd0;
      clk_fs_m = 1'b0; clk_fs_s = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;

      check("rst_addr",    64'(addr_m), 64'd0);
      check("rst_err",     64'(err_m), 64'd0);
      check("rst_e0",      e0_m, 64'd0);
      check("rst_e0ready", 64'(e0ready_m), 64'd0);
      check("rst_busy",    64'(busy_m), 64'd0);
      check("rst_end",     64'(end_m), 64'd0);
      check("rst_overrun", 64'(ovr_m), 64'd0);

      // wrap / stop addressing on the small instances; vref = 255*15/20 = 191
      for (int t = 0; t < 5; t++) begin
         t3 = (t < 4) ? t : 3;
         check($sformatf("wrap_addr_pre%0d", t), 64'(addr_w), 64'(t % 4));
         check($sformatf("stop_addr_pre%0d", t), 64'(addr_s), 64'(t3));
         run_tick_s(lw, nw, ls, ns);
         check($sformatf("wrap_pulses%0d", t), 64'(nw), 64'd1);
         check($sformatf("wrap_lat%0d", t), 64'(lw), 64'd5);
         check($sformatf("wrap_err%0d", t), 64'(err_w), 64'(191 - 10 * (t % 4)));
         check($sformatf("stop_pulses%0d", t), 64'(ns), (t < 4) ? 64'd1 : 64'd0);
         if (t < 4) check($sformatf("stop_lat%0d", t), 64'(ls), 64'd5);
         check($sformatf("stop_end%0d", t), 64'(end_s), (t >= 3) ? 64'd1 : 64'd0);
         check($sformatf("stop_err%0d", t), 64'(err_s), 64'(191 - 10 * t3));
      end
      check("wrap_addr_final", 64'(addr_w), 64'd1);
      check("stop_addr_final", 64'(addr_s), 64'd3);
      check("wrap_end",        64'(end_w), 64'd0);
      check("stop_overrun",    64'(ovr_s), 64'd0);

      // default vref 3071, rom 0
      run_tick(0, lat, np);
      check("t1_lat",    64'(lat), 64'd4);
      check("t1_pulses", 64'(np), 64'd1);
      check("t1_err",    64'(err_m), 64'hBFF);
      check("t1_e0",     e0_m, 64'h40A7FE0000000000);
      check("t1_addr",   64'(addr_m), 64'd1);

      // rom 4095 -> -1024
      run_tick(0, lat, np);
      check("t2_err",    64'(err_m), 64'h1C00);
      check("t2_e0",     e0_m, 64'hC090000000000000);
      check("t2_addr",   64'(addr_m), 64'd2);

      // rom 3071 -> zero
      run_tick(0, lat, np);
      check("t3_err",    64'(err_m), 64'd0);
      check("t3_e0",     e0_m, 64'h0);

      // second tick while busy, rom 100 -> 2971
      run_tick(2, lat, np);
      check("ovr_pulses", 64'(np), 64'd1);
      check("ovr_lat",    64'(lat), 64'd4);
      check("ovr_flag",   64'(ovr_m), 64'd1);
      check("ovr_err",    64'(err_m), 64'hB9B);
      check("ovr_e0",     e0_m, 64'h40A7360000000000);
      check("ovr_addr",   64'(addr_m), 64'd4);

      // tick with en low is ignored
      en = 1'b0;
      run_tick(0, lat, np);
      en = 1'b1;
      check("en0_pulses",  64'(np), 64'd0);
      check("en0_overrun", 64'(ovr_m), 64'd1);
      check("en0_addr",    64'(addr_m), 64'd4);

      // loaded vref 2048, rom 2047 -> 1
      @(negedge clk); vref_ld = 1'b1; vref_in = 12'd2048;
      @(negedge clk); vref_ld = 1'b0;
      run_tick(0, lat, np);
      check("vld_pulses", 64'(np), 64'd1);
      check("vld_err",    64'(err_m), 64'd1);
      check("vld_e0",     e0_m, 64'h3FF0000000000000);
      check("vld_addr",   64'(addr_m), 64'd5);

      // reset while in WAIT aborts the conversion
      @(negedge clk); clk_fs_m = 1'b1;
      @(posedge clk); #1; clk_fs_m = 1'b0;
      check("rw_busy_before", 64'(busy_m), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      np = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (e0ready_m) np++;
      end
      check("rw_pulses",  64'(np), 64'd0);
      check("rw_addr",    64'(addr_m), 64'd0);
      check("rw_overrun", 64'(ovr_m), 64'd0);
      check("rw_end",     64'(end_m), 64'd0);
      check("rw_err",     64'(err_m), 64'd0);
      check("rw_e0",      e0_m, 64'd0);

      // normal conversion afterwards, vref back to default
      run_tick(0, lat, np);
      check("post_lat",  64'(lat), 64'd4);
      check("post_err",  64'(err_m), 64'hBFF);
      check("post_e0",   e0_m, 64'h40A7FE0000000000);
      check("post_addr", 64'(addr_m), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rom_error_fp_gen.md
Name: rom_error_fp_gen

Overview:
Parametrised successor to the team's ROM-to-error float generator. Once per sample tick (clk_Fs rising edge, sampled in the clk domain) it reads one reference-profile word from an external synchronous ROM and computes the signed error vref - sample. It converts that error to IEEE-754 double precision internally and asserts a one-cycle e0ready strobe. The strobe feeds the downstream floating-point controller. New over the previous generation: generic width/depth/ROM latency, loadable vref, wrap/stop addressing, overrun detection and synchronous reset.

Parameters:
W, 12, ROM data width in bits (2..32)
AW, 11, ROM address width
DEPTH, 2048, number of valid ROM words (1..2^AW)
START_ADDR, 0, address loaded at reset (< DEPTH)
ROM_LAT, 1, ROM read latency in clk cycles (>=1)
WRAP, 1, 1: address wraps DEPTH-1 -> 0; 0: address holds at DEPTH-1 and sets end_flag
VREF_NUM, 15, default vref numerator
VREF_DEN, 20, default vref denominator; default vref = ((2^W-1)*VREF_NUM)/VREF_DEN, truncated

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
clk_Fs  in  1  sample-rate tick (level), edge-detected in clk domain
en  in  1  enables acceptance of new ticks
vref_ld  in  1  load vref_in into vref register
vref_in  in  W  unsigned reference value
rom_addr  out  AW  ROM address
rom_data  in  W  ROM read data, valid ROM_LAT cycles after rom_addr is stable
err_int  out  W+1  signed error, registered
e0  out  64  IEEE-754 double of err_int
e0ready  out  1  one-cycle result strobe
busy  out  1  high when state != IDLE
end_flag  out  1  sticky; WRAP=0 and last word consumed
overrun  out  1  sticky; tick arrived while busy

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, rom_addr=START_ADDR, vref=default, err_int=0, e0=0, e0ready=0, end_flag=0, overrun=0, tick-history register=0. Reset mid-conversion aborts it: no strobe, no address advance.
- Tick detect: tick = clk_Fs & ~clk_Fs_q, where clk_Fs_q is the registered previous level.
- FSM: IDLE -> WAIT on tick & en & ~end_flag. WAIT lasts ROM_LAT cycles, rom_addr held. -> CALC: err_int <= {0,vref} - {0,rom_data}, computed at W+1 bits signed with no overflow possible. -> CONV: e0 <= double(err_int). -> DONE: e0ready=1 and address advances, then -> IDLE.
- Latency: e0ready is high for exactly one cycle. That cycle starts ROM_LAT+3 clk cycles after the edge at which the tick is sampled. e0 and err_int stay stable until the next CONV/CALC.
- Address advance in DONE: if rom_addr = DEPTH-1, then WRAP=1 -> 0; WRAP=0 -> hold and set end_flag. Otherwise rom_addr+1.
- end_flag=1 blocks further ticks; only rst clears it.
- A tick while busy is ignored and sets overrun (sticky until rst). A tick with en=0 is ignored without setting overrun. en falling mid-conversion does not stop it.
- vref_ld: vref <= vref_in at that edge; CALC uses the vref register value present in its cycle. vref_ld in the CALC cycle itself is seen by the next sample.
- Double conversion: err=0 -> 64'h0. Otherwise sign=err[W], magnitude=|err|, exponent=1023+msb index, mantissa = magnitude bits below the msb, left-justified in 52 bits. The conversion is always exact for W<=32.
- rst during the same cycle as a tick: reset wins.

Test Plan:
1. Defaults (W=12, vref=3071), rom word 0 = 0, one tick -> err_int=3071, e0=64'h40A7FE0000000000, e0ready pulse exactly ROM_LAT+3 cycles after tick, rom_addr 0->1.
2. rom_data=4095 -> err_int=-1024, e0=64'hC090000000000000. rom_data=3071 -> e0=64'h0.
3. DEPTH=4, WRAP=1, 5 ticks -> addresses 0,1,2,3,0. WRAP=0 -> 4th tick sets end_flag, rom_addr holds 3, 5th tick gives no e0ready.
4. Second tick 2 cycles after first -> single e0ready, overrun=1. Tick with en=0 -> nothing, overrun unchanged.
5. vref_ld with vref_in=2048 before tick, rom_data=2047 -> err_int=1, e0=64'h3FF0000000000000.
6. rst asserted in the WAIT state -> no e0ready, rom_addr=START_ADDR, all flags 0. Next tick converts normally.
